// File: rtl/eth_gmii_rx_deframer_if.sv
// GMII receive inputs and AXI-Stream byte outputs of the RX deframer.
// The master modport is the deframer side; slave is the PHY/FIFO side.
interface eth_gmii_rx_deframer_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    modport master (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/eth_gmii_rx_deframer.sv
// GMII RX deframer: strips preamble/SFD and FCS, checks CRC-32, emits AXI-Stream bytes.
// Optional length check enabled by defining ETH_RX_LEN_CHECK_EN.
module eth_gmii_rx_deframer #(
    parameter int unsigned MinFrameLength = 64,
    parameter int unsigned MaxFrameLength = 1518
) (
    input  logic                          rx_clk,
    input  logic                          rx_rst,
    input  logic                          clk_enable_i,
    eth_gmii_rx_deframer_if.master        bus_io,
    output logic                          error_bad_frame_o,
    output logic                          error_bad_fcs_o,
    output logic                          error_bad_len_o
);

    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [1:0] {StIdle, StPayload, StDrop} state_e;

    state_e          state_q, state_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [31:0]     crc_q, crc_d;
    logic            er_seen_q, er_seen_d;
    logic [7:0]      tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            tuser_q, tuser_d;
    logic            err_frame_q, err_frame_d;
    logic            err_fcs_q, err_fcs_d;
    logic            err_len_q, err_len_d;
    logic            len_bad;
    logic            crc_bad;
    logic            bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

`ifdef ETH_RX_LEN_CHECK_EN
    assign len_bad = (32'(cnt_q) < MinFrameLength) || (32'(cnt_q) > MaxFrameLength);
`else
    logic unused_len_cfg;
    assign unused_len_cfg = (MinFrameLength > MaxFrameLength);
    assign len_bad        = 1'b0;
`endif

    assign crc_bad = (crc_q != CrcResidue);
    assign bad     = er_seen_q | crc_bad | len_bad;

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        er_seen_d   = er_seen_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        err_frame_d = 1'b0;
        err_fcs_d   = 1'b0;
        err_len_d   = 1'b0;

        if (clk_enable_i) begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.gmii_rx_dv) begin
                        if (bus_io.gmii_rx_er) begin
                            state_d = StDrop;
                        end else if (bus_io.gmii_rxd == 8'hD5) begin
                            state_d   = StPayload;
                            crc_d     = 32'hFFFFFFFF;
                            cnt_d     = '0;
                            er_seen_d = 1'b0;
                            dly_d     = '0;
                        end else if (bus_io.gmii_rxd != 8'h55) begin
                            state_d = StDrop;
                        end
                    end
                end
                StPayload: begin
                    if (bus_io.gmii_rx_dv) begin
                        crc_d = crc_byte(crc_q, bus_io.gmii_rxd);
                        dly_d = {dly_q[3:0], bus_io.gmii_rxd};
                        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        if (bus_io.gmii_rx_er) er_seen_d = 1'b1;
                        // Once five bytes are buffered, the oldest can no longer be FCS.
                        if (cnt_q >= 16'd5) begin
                            tvalid_d = 1'b1;
                            tdata_d  = dly_q[4];
                        end
                    end else begin
                        state_d   = StIdle;
                        err_fcs_d = crc_bad & ~er_seen_q;
                        err_len_d = len_bad;
                        if (cnt_q >= 16'd5) begin
                            tvalid_d    = 1'b1;
                            tlast_d     = 1'b1;
                            tuser_d     = bad;
                            tdata_d     = dly_q[4];
                            err_frame_d = bad;
                        end else begin
                            err_frame_d = 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (!bus_io.gmii_rx_dv) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q     <= StIdle;
            dly_q       <= '0;
            cnt_q       <= '0;
            crc_q       <= 32'hFFFFFFFF;
            er_seen_q   <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            err_frame_q <= 1'b0;
            err_fcs_q   <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            er_seen_q   <= er_seen_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            err_frame_q <= err_frame_d;
            err_fcs_q   <= err_fcs_d;
            err_len_q   <= err_len_d;
        end
    end

    assign bus_io.m_axis_tdata  = tdata_q;
    assign bus_io.m_axis_tvalid = tvalid_q;
    assign bus_io.m_axis_tlast  = tlast_q;
    assign bus_io.m_axis_tuser  = tuser_q;
    assign error_bad_frame_o    = err_frame_q;
    assign error_bad_fcs_o      = err_fcs_q;
    assign error_bad_len_o      = err_len_q;

endmodule

// File: tb/tb_eth_gmii_rx_deframer.sv
// Randomized bench for eth_gmii_rx_deframer against a frame-level reference model.
// Build with ETH_RX_LEN_CHECK_EN defined to exercise the length check.
module tb_eth_gmii_rx_deframer;

`ifdef ETH_RX_LEN_CHECK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    logic rx_clk = 1'b0;
    logic rx_rst = 1'b1;
    logic clk_enable = 1'b0;
    logic err_frame, err_fcs, err_len;

    eth_gmii_rx_deframer_if bus ();

    eth_gmii_rx_deframer dut (
        .rx_clk           (rx_clk),
        .rx_rst           (rx_rst),
        .clk_enable_i     (clk_enable),
        .bus_io           (bus.master),
        .error_bad_frame_o(err_frame),
        .error_bad_fcs_o  (err_fcs),
        .error_bad_len_o  (err_len)
    );

    always #5 rx_clk = ~rx_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed beats {tuser, tlast, tdata} and error pulse counts.
    logic [9:0] beats[$];
    int cnt_frame, cnt_fcs, cnt_len, cnt_b2b;
    logic prev_valid = 1'b0;
    bit ce_toggle = 1'b0;

    always @(posedge rx_clk) begin
        #1;
        if (!rx_rst) begin
            if (bus.m_axis_tvalid) begin
                beats.push_back({bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata});
                if (prev_valid) cnt_b2b++;
            end
            if (err_frame) cnt_frame++;
            if (err_fcs) cnt_fcs++;
            if (err_len) cnt_len++;
        end
        prev_valid = bus.m_axis_tvalid;
    end

    task automatic clear_obs();
        beats.delete();
        cnt_frame = 0;
        cnt_fcs   = 0;
        cnt_len   = 0;
        cnt_b2b   = 0;
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                if ((c[0] ^ q[i][k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic make_frame(input int plen, output logic [7:0] q[$]);
        logic [31:0] f;
        q.delete();
        for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
        f = fcs_of(q, plen);
        for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    endtask

    // Disabled cycles carry random junk to prove they are ignored.
    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge rx_clk);
        bus.gmii_rx_dv = dv;
        bus.gmii_rx_er = er;
        bus.gmii_rxd   = d;
        clk_enable     = 1'b1;
        if (ce_toggle) begin
            @(negedge rx_clk);
            clk_enable     = 1'b0;
            bus.gmii_rx_dv = 1'($urandom);
            bus.gmii_rx_er = 1'($urandom);
            bus.gmii_rxd   = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input int er_idx);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < q.size(); i++) drive(1'b1, (i == er_idx), q[i]);
        ce_toggle = 1'b0;
        idle(12);
    endtask

    // Reference: payload is everything but the last four bytes; FCS compared as a value.
    task automatic check_frame(input string tag, input logic [7:0] q[$], input int er_idx,
                               input bit toggled);
        int n;
        bit er, crc_bad, len_bad, bad;
        logic [31:0] rx_fcs;
        n       = q.size();
        er      = (er_idx >= 0) && (er_idx < n);
        len_bad = LenChk && ((n < 64) || (n > 1518));
        if (n >= 5) begin
            rx_fcs  = {q[n-1], q[n-2], q[n-3], q[n-4]};
            crc_bad = (fcs_of(q, n - 4) != rx_fcs);
            bad     = er || crc_bad || len_bad;
            check_eq({tag, " beats"}, beats.size(), n - 4);
            for (int i = 0; i < n - 4 && i < beats.size(); i++) begin
                check_eq($sformatf("%s b%0d data", tag, i), beats[i][7:0], q[i]);
                check_eq($sformatf("%s b%0d last", tag, i), beats[i][8], (i == n - 5));
            end
            if (beats.size() > 0) check_eq({tag, " tuser"}, beats[$][9], bad);
            check_eq({tag, " bad_frame"}, cnt_frame, bad);
            check_eq({tag, " bad_fcs"}, cnt_fcs, crc_bad && !er);
            if (toggled) check_eq({tag, " b2b valid"}, cnt_b2b, 0);
        end else begin
            check_eq({tag, " runt beats"}, beats.size(), 0);
            check_eq({tag, " runt bad_frame"}, cnt_frame, 1);
        end
        check_eq({tag, " bad_len"}, cnt_len, len_bad);
        clear_obs();
    endtask

    logic [7:0] frm[$];

    initial begin
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
        clear_obs();
        repeat (3) @(negedge rx_clk);
        check_eq("rst tvalid", bus.m_axis_tvalid, 0);
        check_eq("rst tlast", bus.m_axis_tlast, 0);
        check_eq("rst tuser", bus.m_axis_tuser, 0);
        check_eq("rst tdata", bus.m_axis_tdata, 0);
        check_eq("rst errs", {err_frame, err_fcs, err_len}, 0);
        rx_rst = 1'b0;
        idle(4);
        clear_obs();

        // Good 60-byte payload.
        make_frame(60, frm);
        send_frame(frm, -1);
        check_frame("t1", frm, -1, 1'b0);

        // Corrupted FCS byte.
        make_frame(60, frm);
        frm[61] = frm[61] ^ 8'h01;
        send_frame(frm, -1);
        check_frame("t2", frm, -1, 1'b0);

        // rx_er on data byte 20.
        make_frame(60, frm);
        send_frame(frm, 20);
        check_frame("t3", frm, 20, 1'b0);

        // Sparse clock enable.
        make_frame(60, frm);
        ce_toggle = 1'b1;
        send_frame(frm, -1);
        check_frame("t4", frm, -1, 1'b1);

        // Asynchronous reset mid-frame, then a clean frame.
        make_frame(60, frm);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, frm[i]);
        @(posedge rx_clk);
        #2;
        rx_rst = 1'b1;
        #1;
        check_eq("t5 rst tvalid", bus.m_axis_tvalid, 0);
        check_eq("t5 rst tdata", bus.m_axis_tdata, 0);
        check_eq("t5 rst errs", {bus.m_axis_tlast, bus.m_axis_tuser, err_frame, err_fcs, err_len}, 0);
        begin
            int lasts = 0;
            foreach (beats[i]) if (beats[i][8]) lasts++;
            check_eq("t5 partial no tlast", lasts, 0);
        end
        bus.gmii_rx_dv = 1'b0;
        repeat (3) @(negedge rx_clk);
        rx_rst = 1'b0;
        idle(4);
        clear_obs();
        make_frame(60, frm);
        send_frame(frm, -1);
        check_frame("t5 after", frm, -1, 1'b0);

        // Runt: three bytes after SFD.
        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
        send_frame(frm, -1);
        check_frame("t6 runt", frm, -1, 1'b0);

`ifdef ETH_RX_LEN_CHECK_EN
        make_frame(36, frm);
        send_frame(frm, -1);
        check_frame("t6 short", frm, -1, 1'b0);
`endif

        // Randomized mix.
        for (int f = 0; f < 24; f++) begin
            int er_idx;
            bit tog;
            er_idx = -1;
            if ($urandom_range(0, 9) == 0) begin
                frm.delete();
                for (int i = 0; i < int'($urandom_range(0, 4)); i++) frm.push_back(8'($urandom));
            end else begin
                make_frame(int'($urandom_range(40, 120)), frm);
                if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, frm.size() - 1)] ^= 8'h10;
                if ($urandom_range(0, 3) == 0) er_idx = int'($urandom_range(0, frm.size() - 1));
            end
            tog = ($urandom_range(0, 3) == 0);
            ce_toggle = tog;
            send_frame(frm, er_idx);
            check_frame($sformatf("rnd%0d", f), frm, er_idx, tog);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
